pipe_skid_latch: RTL and testbench

PIPE_SKID_LATCH -- requirements
Module: pipe_skid_latch

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_reg_w.sv | 21 ++
 rtl/pipe_skid_latch.sv | 154 +++++++++++++++
 tb/tb_pipe_skid_latch.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the two-entry skid latch: state encoding and the
// control-vector bubble constant.
package pipe_pkg;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int OCC_W    = 2;
  localparam int CTRL_MAX = 64;

  // All-zero control word; sliced down to CTRL_W by users (CTRL_W <= CTRL_MAX).
  localparam logic [CTRL_MAX-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_reg_w.sv
// Parametrised-width storage register with load enable and async active-low clear.
module pipe_reg_w #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)    r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_latch.sv
// Two-entry FIFO pipeline latch (HEAD + SKID) with registered in_ready,
// synchronous flush and a saturating downstream bubble counter.
module pipe_skid_latch
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 7,
  parameter int TAG_W  = 51,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int HEAD = 0;
  localparam int SKID = 1;

  pipe_state_e r_state, w_state_nxt;

  logic w_push, w_pop;
  logic w_ld_head, w_ld_skid, w_head_from_skid;
  logic [1:0] w_en;

  logic [1:0][TAG_W-1:0]  w_tag_d,  w_tag_q;
  logic [1:0][DATA_W-1:0] w_a_d,    w_a_q;
  logic [1:0][DATA_W-1:0] w_b_d,    w_b_q;
  logic [1:0][DATA_W-1:0] w_pc_d,   w_pc_q;
  logic [1:0][CTRL_W-1:0] w_ctrl_d, w_ctrl_q;

  logic [CNT_W-1:0] r_bubble;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; flush wins over any handshake in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
        ST_ONE: begin
          if (w_push && !w_pop)      w_state_nxt = ST_FULL;
          else if (!w_push && w_pop) w_state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (w_pop) w_state_nxt = ST_ONE;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Handshake and head-entry outputs depend on registered state only.
  always_comb begin
    in_ready  = (r_state != ST_FULL);
    out_valid = (r_state != ST_EMPTY);
    occupancy = r_state;
    out_ctrl  = out_valid ? w_ctrl_q[HEAD] : CTRL_NOP[CTRL_W-1:0];
  end

  assign out_tag = w_tag_q[HEAD];
  assign out_a   = w_a_q[HEAD];
  assign out_b   = w_b_q[HEAD];
  assign out_pc  = w_pc_q[HEAD];

  // Load enables: a dropped (flushed) input never reaches storage, and
  // nothing toggles while the stage stalls.
  always_comb begin
    w_ld_head        = 1'b0;
    w_ld_skid        = 1'b0;
    w_head_from_skid = 1'b0;
    if (!flush) begin
      case (r_state)
        ST_EMPTY: w_ld_head = w_push;
        ST_ONE: begin
          w_ld_head = w_push & w_pop;
          w_ld_skid = w_push & ~w_pop;
        end
        ST_FULL: begin
          w_ld_head        = w_pop;
          w_head_from_skid = w_pop;
        end
        default: ;
      endcase
    end
  end

  assign w_en[HEAD] = w_ld_head;
  assign w_en[SKID] = w_ld_skid;

  assign w_tag_d[HEAD]  = w_head_from_skid ? w_tag_q[SKID]  : in_tag;
  assign w_a_d[HEAD]    = w_head_from_skid ? w_a_q[SKID]    : in_a;
  assign w_b_d[HEAD]    = w_head_from_skid ? w_b_q[SKID]    : in_b;
  assign w_pc_d[HEAD]   = w_head_from_skid ? w_pc_q[SKID]   : in_pc;
  assign w_ctrl_d[HEAD] = w_head_from_skid ? w_ctrl_q[SKID] : in_ctrl;

  assign w_tag_d[SKID]  = in_tag;
  assign w_a_d[SKID]    = in_a;
  assign w_b_d[SKID]    = in_b;
  assign w_pc_d[SKID]   = in_pc;
  assign w_ctrl_d[SKID] = in_ctrl;

  for (genvar e = 0; e < 2; e++) begin : g_ent
    pipe_reg_w #(.W(TAG_W)) u_tag (
      .clk(clk), .clr_n(clr_n), .i_en(w_en[e]), .i_d(w_tag_d[e]), .o_q(w_tag_q[e])
    );
    pipe_reg_w #(.W(DATA_W)) u_a (
      .clk(clk), .clr_n(clr_n), .i_en(w_en[e]), .i_d(w_a_d[e]), .o_q(w_a_q[e])
    );
    pipe_reg_w #(.W(DATA_W)) u_b (
      .clk(clk), .clr_n(clr_n), .i_en(w_en[e]), .i_d(w_b_d[e]), .o_q(w_b_q[e])
    );
    pipe_reg_w #(.W(DATA_W)) u_pc (
      .clk(clk), .clr_n(clr_n), .i_en(w_en[e]), .i_d(w_pc_d[e]), .o_q(w_pc_q[e])
    );
    pipe_reg_w #(.W(CTRL_W)) u_ctrl (
      .clk(clk), .clr_n(clr_n), .i_en(w_en[e]), .i_d(w_ctrl_d[e]), .o_q(w_ctrl_q[e])
    );
  end

  // Bubble counter survives flush; only reset clears it.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      r_bubble <= '0;
    else if (out_ready && !out_valid && !(&r_bubble))
      r_bubble <= r_bubble + CNT_W'(1);
  end

  assign bubble_cnt = r_bubble;

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Directed and scoreboard-checked stimulus for pipe_skid_latch.
module tb_pipe_skid_latch;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 7;
  localparam int TAG_W  = 51;

  logic clk, clr_n, flush, in_valid, out_ready;
  logic [TAG_W-1:0]  in_tag;
  logic [DATA_W-1:0] in_a, in_b, in_pc;
  logic [CTRL_W-1:0] in_ctrl;
  logic in_ready, out_valid;
  logic [TAG_W-1:0]  out_tag;
  logic [DATA_W-1:0] out_a, out_b, out_pc;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [15:0]       bubble_cnt;

  logic in_ready2, out_valid2;
  logic [TAG_W-1:0]  out_tag2;
  logic [DATA_W-1:0] out_a2, out_b2, out_pc2;
  logic [CTRL_W-1:0] out_ctrl2;
  logic [1:0]        occupancy2;
  logic [1:0]        bubble_cnt2;

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;

  typedef struct { logic [TAG_W-1:0] tag; logic [DATA_W-1:0] a; } ent_t;
  ent_t q[$];

  pipe_skid_latch dut (
    .clk(clk), .clr_n(clr_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_tag(in_tag), .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_a(out_a),
    .out_b(out_b), .out_pc(out_pc), .out_ctrl(out_ctrl), .occupancy(occupancy),
    .bubble_cnt(bubble_cnt)
  );

  pipe_skid_latch #(.CNT_W(2)) dut2 (
    .clk(clk), .clr_n(clr_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_tag(in_tag), .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_ctrl(in_ctrl),
    .out_valid(out_valid2), .out_ready(out_ready), .out_tag(out_tag2), .out_a(out_a2),
    .out_b(out_b2), .out_pc(out_pc2), .out_ctrl(out_ctrl2), .occupancy(occupancy2),
    .bubble_cnt(bubble_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] a, input logic [CTRL_W-1:0] c);
    in_valid = v;
    in_a     = a;
    in_b     = a ^ 32'hFFFF_0000;
    in_pc    = a + 32'h100;
    in_tag   = {19'd0, a};
    in_ctrl  = c;
  endtask

  initial begin
    clr_n = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 7'h0);
    #2 clr_n = 1'b0;
    #1;
    chk("rst_vld",   out_valid,  0);
    chk("rst_ctrl",  out_ctrl,   0);
    chk("rst_rdy",   in_ready,   1);
    chk("rst_occ",   occupancy,  0);
    chk("rst_bub",   bubble_cnt, 0);
    cyc(); cyc();
    clr_n = 1'b1;
    cyc();

    // idle bubbles from reset; narrow counter saturates
    out_ready = 1'b1;
    repeat (5) cyc();
    chk("bub5",      bubble_cnt,  5);
    chk("bub_sat",   bubble_cnt2, 3);

    // single entry latency, then streaming
    drive(1'b1, 32'h1234, 7'h5A);
    cyc();
    chk("lat_vld",   out_valid, 1);
    chk("lat_a",     out_a,     32'h1234);
    chk("lat_ctrl",  out_ctrl,  7'h5A);
    chk("lat_pc",    out_pc,    32'h1334);
    chk("lat_occ",   occupancy, 1);
    chk("lat_bub",   bubble_cnt, 6);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'h1234 + i, 7'h11);
      cyc();
      chk("strm_a",   out_a,     32'h1234 + i);
      chk("strm_occ", occupancy, 1);
      chk("strm_rdy", in_ready,  1);
    end
    drive(1'b0, 32'hDEAD, 7'h7F);
    cyc();
    chk("drain_vld",  out_valid, 0);
    chk("drain_ctrl", out_ctrl,  0);
    chk("drain_hold", out_a,     32'h1237);
    chk("drain_bub",  bubble_cnt, 6);

    // backpressure fill then ordered drain
    out_ready = 1'b0;
    drive(1'b1, 32'h1, 7'h01);
    cyc();
    chk("bp1_occ", occupancy, 1);
    chk("bp1_a",   out_a,     1);
    drive(1'b1, 32'h2, 7'h02);
    cyc();
    chk("bp2_occ", occupancy, 2);
    chk("bp2_rdy", in_ready,  0);
    chk("bp2_a",   out_a,     1);
    drive(1'b1, 32'h9, 7'h09);
    cyc();
    chk("stall_occ", occupancy, 2);
    chk("stall_a",   out_a,     1);
    drive(1'b0, 32'h0, 7'h0);
    out_ready = 1'b1;
    cyc();
    chk("pop1_a",    out_a,     2);
    chk("pop1_ctrl", out_ctrl,  7'h02);
    chk("pop1_occ",  occupancy, 1);
    cyc();
    chk("pop2_vld",  out_valid, 0);
    chk("pop2_occ",  occupancy, 0);

    // flush while full drops the concurrent input
    out_ready = 1'b0;
    drive(1'b1, 32'h10, 7'h10); cyc();
    drive(1'b1, 32'h11, 7'h11); cyc();
    chk("fl_full", occupancy, 2);
    flush = 1'b1;
    drive(1'b1, 32'h3, 7'h33);
    cyc();
    chk("fl_occ",  occupancy, 0);
    chk("fl_vld",  out_valid, 0);
    chk("fl_ctrl", out_ctrl,  0);
    chk("fl_rdy",  in_ready,  1);
    flush = 1'b0;
    drive(1'b0, 32'h0, 7'h0);
    out_ready = 1'b1;
    cyc();
    chk("fl_no3",  out_valid, 0);
    chk("fl_bub",  bubble_cnt, 7);

    // asynchronous clear while full
    out_ready = 1'b0;
    drive(1'b1, 32'h20, 7'h20); cyc();
    drive(1'b1, 32'h21, 7'h21); cyc();
    chk("ac_full", occupancy, 2);
    drive(1'b0, 32'h0, 7'h0);
    #1 clr_n = 1'b0;
    #1;
    chk("ac_vld", out_valid,  0);
    chk("ac_rdy", in_ready,   1);
    chk("ac_occ", occupancy,  0);
    chk("ac_bub", bubble_cnt, 0);
    chk("ac_a",   out_a,      0);
    #1 clr_n = 1'b1;
    cyc();
    chk("ac_idle", out_valid, 0);
    out_ready = 1'b1;
    drive(1'b1, 32'h30, 7'h30);
    cyc();
    chk("ac_res_a",   out_a,     32'h30);
    chk("ac_res_occ", occupancy, 1);
    drive(1'b0, 32'h0, 7'h0);
    cyc();
    chk("ac_empty", occupancy, 0);

    // random handshakes against a scoreboard FIFO
    for (int i = 0; i < 10000; i++) begin
      logic push, pop;
      ent_t e;
      chk("r_vld", out_valid, q.size() != 0);
      chk("r_rdy", in_ready,  q.size() < 2);
      chk("r_occ", occupancy, q.size());
      if (q.size() != 0) begin
        chk("r_a",   out_a,   q[0].a);
        chk("r_tag", out_tag, q[0].tag);
      end
      drive(1'($urandom_range(0, 1)), $urandom, 7'($urandom));
      in_tag    = TAG_W'(i);
      out_ready = 1'($urandom_range(0, 1));
      push = in_valid && (q.size() < 2);
      pop  = out_ready && (q.size() != 0);
      e.tag = in_tag;
      e.a   = in_a;
      cyc();
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
